// File: rtl/msx_slot_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module  : msx_slot_decoder_pkg
// Purpose : Shared types and defaults for the MSX primary/secondary slot
//           decoder: handshake FSM state type, default register addresses,
//           and a helper that extracts a per-page 2-bit slot field.
// Rev     : 1.0  initial release
// ============================================================================
package msx_slot_decoder_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    M1W  = 3'd1,
    REQ  = 3'd2,
    WAIT = 3'd3,
    HOLD = 3'd4
  } slot_fsm_t;

  localparam logic [7:0]  C_PRIM_PORT_DEF = 8'hA8;
  localparam logic [15:0] C_EXP_ADDR_DEF  = 16'hFFFF;
  localparam logic [7:0]  C_BUS_IDLE      = 8'hFF;

  // Slot registers pack four 2-bit fields, one per 16 KB page.
  function automatic logic [1:0] page_field(input logic [7:0] reg_val,
                                            input logic [1:0] page);
    page_field = reg_val[{page, 1'b0} +: 2];
  endfunction

endpackage
`default_nettype wire

// File: rtl/msx_slot_decoder_handshake.sv
`default_nettype none
// ============================================================================
// Module  : slot_mem_handshake
// Purpose : Turns a CPU memory cycle into a single req/ack transaction with
//           the memory back end, stretches the CPU with wait, aborts after
//           TIMEOUT wait cycles, and latches the read data for the CPU.
// Ports   : clk, reset         - clock, synchronous active-high reset
//           cpu_mreq/rd/wr     - CPU strobes
//           m1_fetch           - M1 opcode fetch (only with MSX_SLOT_M1_WAIT_EN)
//           map_hit, exp_hit   - page is mapped / access hits expander reg
//           mem_ack, mem_rdata - back end completion and read data
//           cpu_wait           - CPU wait request
//           mem_req, mem_rnw   - back end request and direction
//           timeout_err        - sticky timeout flag
//           hold_rd            - FSM in HOLD (latched data is presentable)
//           rdata              - latched read data
// Config  : MSX_SLOT_M1_WAIT_EN adds one wait state (M1W) to every M1 fetch.
// Rev     : 1.0  initial release
// ============================================================================
module slot_mem_handshake
  import msx_slot_decoder_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cpu_mreq,
  input  logic       cpu_rd,
  input  logic       cpu_wr,
`ifdef MSX_SLOT_M1_WAIT_EN
  input  logic       m1_fetch,
`endif
  input  logic       map_hit,
  input  logic       exp_hit,
  input  logic       mem_ack,
  input  logic [7:0] mem_rdata,
  output logic       cpu_wait,
  output logic       mem_req,
  output logic       mem_rnw,
  output logic       timeout_err,
  output logic       hold_rd,
  output logic [7:0] rdata
);

  localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

  slot_fsm_t        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_mem_req;
  logic             r_rnw;
  logic             r_terr;
  logic [7:0]       r_rdata;
  logic             w_start;

  assign w_start = (r_state == IDLE) & cpu_mreq & (cpu_rd | cpu_wr) & map_hit & ~exp_hit;

`ifdef MSX_SLOT_M1_WAIT_EN
  logic r_m1_mapped;
  logic w_m1_go;
  // Unmapped fetches also take the extra state, so this does not need map_hit.
  assign w_m1_go = (r_state == IDLE) & m1_fetch & ~exp_hit;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_mem_req <= 1'b0;
      r_rnw     <= 1'b1;
      r_terr    <= 1'b0;
      r_rdata   <= C_BUS_IDLE;
`ifdef MSX_SLOT_M1_WAIT_EN
      r_m1_mapped <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
`ifdef MSX_SLOT_M1_WAIT_EN
          if (w_m1_go) begin
            r_state     <= M1W;
            r_rnw       <= 1'b1;
            r_m1_mapped <= map_hit;
          end else
`endif
          if (w_start) begin
            r_state   <= REQ;
            r_rnw     <= ~cpu_wr;
            r_cnt     <= '0;
            r_mem_req <= 1'b1;
          end
        end
`ifdef MSX_SLOT_M1_WAIT_EN
        M1W: begin
          if (r_m1_mapped) begin
            r_state   <= REQ;
            r_cnt     <= '0;
            r_mem_req <= 1'b1;
          end else begin
            r_state <= HOLD;
            r_rdata <= C_BUS_IDLE;
          end
        end
`endif
        REQ, WAIT: begin
          // An ack arriving in REQ completes the transfer just as in WAIT.
          if (mem_ack) begin
            if (r_rnw) r_rdata <= mem_rdata;
            r_state   <= HOLD;
            r_mem_req <= 1'b0;
          end else if ((r_state == WAIT) && (r_cnt == C_TIMEOUT)) begin
            r_rdata   <= C_BUS_IDLE;
            r_terr    <= 1'b1;
            r_state   <= HOLD;
            r_mem_req <= 1'b0;
          end else begin
            r_state <= WAIT;
            if ((r_state == WAIT) && (r_cnt != C_CNT_MAX)) r_cnt <= r_cnt + 1'b1;
          end
        end
        // Stay here until the CPU ends its cycle so one cycle gives one request.
        HOLD: if (!cpu_mreq) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cpu_wait    = w_start | (r_state == M1W) | (r_state == REQ) | (r_state == WAIT);
  assign mem_req     = r_mem_req;
  assign mem_rnw     = r_rnw;
  assign timeout_err = r_terr;
  assign hold_rd     = (r_state == HOLD);
  assign rdata       = r_rdata;

endmodule
`default_nettype wire

// File: rtl/msx_slot_decoder.sv
`default_nettype none
// ============================================================================
// Module  : msx_slot_decoder
// Purpose : MSX primary/secondary slot decoder. Holds the primary slot
//           register (I/O PRIM_PORT) and one expander register per primary
//           slot (memory EXP_ADDR), forms layout_id {slot,subslot,page} for
//           the slot map, and hands mapped memory cycles to the handshake.
// Ports   : clk, reset            - clock, synchronous active-high reset
//           cpu_*                 - Z80 bus (addr, dout, din, rd, wr, mreq,
//                                   iorq, m1, wait)
//           exp_en                - per primary slot: expander present
//           map_hit               - slot map says layout_id is populated
//           active_slot/sub       - slot and subslot of the addressed page
//           layout_id, prim_reg   - slot map index, primary slot register
//           mem_req/rnw/ack/rdata - memory back end handshake
//           timeout_err           - sticky back end timeout
// Config  : MSX_SLOT_M1_WAIT_EN - one extra wait state on every M1 fetch.
// Rev     : 1.0  initial release
// ============================================================================
module msx_slot_decoder
  import msx_slot_decoder_pkg::*;
#(
  parameter logic [7:0]  PRIM_PORT = C_PRIM_PORT_DEF,
  parameter logic [15:0] EXP_ADDR  = C_EXP_ADDR_DEF,
  parameter int          TIMEOUT   = 255,
  parameter int          CNT_W     = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  output logic [7:0]  cpu_din,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic        cpu_mreq,
  input  logic        cpu_iorq,
  input  logic        cpu_m1,
  output logic        cpu_wait,
  input  logic [3:0]  exp_en,
  input  logic        map_hit,
  output logic [1:0]  active_slot,
  output logic [1:0]  active_sub,
  output logic [5:0]  layout_id,
  output logic [7:0]  prim_reg,
  output logic        mem_req,
  output logic        mem_rnw,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic        timeout_err
);

  logic [7:0] r_prim;
  logic [7:0] r_exp [4];

  logic [1:0] w_page;
  logic [1:0] w_exp_sel;
  logic [1:0] w_slot;
  logic [1:0] w_sub;
  logic       w_prim_sel;
  logic       w_exp_hit;
  logic       w_hold_rd;
  logic [7:0] w_rdata;

  assign w_page     = cpu_addr[15:14];
  // The expander register at EXP_ADDR belongs to the slot selected for page 3.
  assign w_exp_sel  = r_prim[7:6];
  assign w_slot     = page_field(r_prim, w_page);
  assign w_sub      = exp_en[w_slot] ? page_field(r_exp[w_slot], w_page) : 2'b00;
  // M1 together with IORQ is an interrupt acknowledge, not a port access.
  assign w_prim_sel = cpu_iorq & ~cpu_m1 & (cpu_addr[7:0] == PRIM_PORT);
  assign w_exp_hit  = cpu_mreq & (cpu_addr == EXP_ADDR) & exp_en[w_exp_sel];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_prim <= 8'h00;
      for (int i = 0; i < 4; i++) r_exp[i] <= 8'h00;
    end else begin
      if (w_prim_sel & cpu_wr) r_prim <= cpu_dout;
      if (w_exp_hit & cpu_wr) r_exp[w_exp_sel] <= cpu_dout;
    end
  end

  slot_mem_handshake #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_handshake (
    .clk         (clk),
    .reset       (reset),
    .cpu_mreq    (cpu_mreq),
    .cpu_rd      (cpu_rd),
    .cpu_wr      (cpu_wr),
`ifdef MSX_SLOT_M1_WAIT_EN
    .m1_fetch    (cpu_mreq & cpu_rd & cpu_m1),
`endif
    .map_hit     (map_hit),
    .exp_hit     (w_exp_hit),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .cpu_wait    (cpu_wait),
    .mem_req     (mem_req),
    .mem_rnw     (mem_rnw),
    .timeout_err (timeout_err),
    .hold_rd     (w_hold_rd),
    .rdata       (w_rdata)
  );

  // Expander reads return the inverted register, as real MSX expanders do.
  always_comb begin
    cpu_din = C_BUS_IDLE;
    if (w_exp_hit & cpu_rd)                  cpu_din = ~r_exp[w_exp_sel];
    else if (w_prim_sel & cpu_rd)            cpu_din = r_prim;
    else if (cpu_mreq & cpu_rd & w_hold_rd)  cpu_din = w_rdata;
  end

  assign active_slot = w_slot;
  assign active_sub  = w_sub;
  assign layout_id   = {w_slot, w_sub, w_page};
  assign prim_reg    = r_prim;

endmodule
`default_nettype wire

// File: tb/tb_msx_slot_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_msx_slot_decoder
// Purpose : Scoreboard bench for msx_slot_decoder. Stimulus pushes expected
//           per-cycle results computed from a slot model; a bus monitor pops
//           and compares when each CPU cycle reaches its data phase.
// Config  : honours MSX_SLOT_M1_WAIT_EN in its model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_msx_slot_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic [7:0]  cpu_din;
  logic        cpu_rd, cpu_wr, cpu_mreq, cpu_iorq, cpu_m1;
  logic        cpu_wait;
  logic [3:0]  exp_en;
  logic        map_hit;
  logic [1:0]  active_slot, active_sub;
  logic [5:0]  layout_id;
  logic [7:0]  prim_reg;
  logic        mem_req, mem_rnw, mem_ack;
  logic [7:0]  mem_rdata;
  logic        timeout_err;

  logic [63:0] slot_map;
  logic        be_ack;
  logic        stray_ack;
  int          be_after;
  int          be_age;
  logic [7:0]  be_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign map_hit = slot_map[layout_id];
  assign mem_ack = be_ack | stray_ack;

  msx_slot_decoder dut (
    .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
    .cpu_din(cpu_din), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_mreq(cpu_mreq),
    .cpu_iorq(cpu_iorq), .cpu_m1(cpu_m1), .cpu_wait(cpu_wait), .exp_en(exp_en),
    .map_hit(map_hit), .active_slot(active_slot), .active_sub(active_sub),
    .layout_id(layout_id), .prim_reg(prim_reg), .mem_req(mem_req),
    .mem_rnw(mem_rnw), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .timeout_err(timeout_err)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Memory back end: acks be_after+1 cycles into a request (-1: never).
  always @(posedge clk) begin
    #1;
    if (mem_req) be_age = be_age + 1; else be_age = 0;
    if (be_after >= 0 && mem_req && be_age == be_after + 1) begin
      be_ack    = 1'b1;
      mem_rdata = be_data;
    end else begin
      be_ack    = 1'b0;
      mem_rdata = 8'($urandom);
    end
  end

  // ---------------- reference model + scoreboard ----------------
  typedef struct {
    int         waits;
    int         bursts;
    logic [5:0] layout;
    bit         is_rd;
    logic [7:0] din;
    bit         terr;
  } exp_t;

  exp_t sb[$];
  int   m_prim;
  int   m_exp[4];
  bit   m_terr;

  task automatic model_reset();
    m_prim = 0;
    for (int i = 0; i < 4; i++) m_exp[i] = 0;
    m_terr = 1'b0;
  endtask

  task automatic push_expect(input bit is_io, input bit is_wr, input bit m1,
                             input logic [15:0] addr, input logic [7:0] data,
                             input int ack_after, input logic [7:0] rdval);
    exp_t e;
    int pg, sl, sub, sel, extra;
    bit hit;
    pg  = int'(addr[15:14]);
    sl  = (m_prim >> (2 * pg)) % 4;
    sub = exp_en[sl] ? (m_exp[sl] >> (2 * pg)) % 4 : 0;
    sel = m_prim / 64;
    e.layout = 6'(sl * 16 + sub * 4 + pg);
    e.is_rd  = !is_wr;
    e.din    = 8'hFF;
    e.waits  = 0;
    e.bursts = 0;
    hit = !is_io && addr == 16'hFFFF && exp_en[sel];
    extra = 0;
`ifdef MSX_SLOT_M1_WAIT_EN
    if (m1 && !is_wr && !is_io) extra = 1;
`endif
    if (is_io) begin
      if (addr[7:0] == 8'hA8) begin
        if (is_wr) m_prim = int'(data);
        else e.din = 8'(m_prim);
      end
    end else if (hit) begin
      if (is_wr) m_exp[sel] = int'(data);
      else e.din = ~8'(m_exp[sel]);
    end else if (slot_map[e.layout]) begin
      e.bursts = 1;
      if (ack_after < 0) begin
        e.waits = 258 + extra;
        m_terr  = 1'b1;
      end else begin
        e.waits = ack_after + 2 + extra;
        if (!is_wr) e.din = rdval;
      end
    end else begin
      e.waits = extra;
    end
    e.terr = m_terr;
    sb.push_back(e);
  endtask

  task automatic cpu_cycle(input bit is_io, input bit is_wr, input bit m1,
                           input logic [15:0] addr, input logic [7:0] data);
    int n;
    @(posedge clk); #1;
    cpu_addr = addr; cpu_dout = data;
    cpu_mreq = !is_io; cpu_iorq = is_io;
    cpu_rd = !is_wr; cpu_wr = is_wr; cpu_m1 = m1;
    n = 0;
    @(negedge clk);
    while (cpu_wait && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (cpu_wait) begin
      checks++; errors++;
      $display("FAIL wait_bound: cpu_wait still high after %0d clocks, required low", n);
    end
    @(posedge clk); #1;
    cpu_mreq = 0; cpu_iorq = 0; cpu_rd = 0; cpu_wr = 0; cpu_m1 = 0;
  endtask

  task automatic txn(input bit is_io, input bit is_wr, input bit m1,
                     input logic [15:0] addr, input logic [7:0] data,
                     input int ack_after, input logic [7:0] rdval);
    be_after = ack_after;
    be_data  = rdval;
    push_expect(is_io, is_wr, m1, addr, data, ack_after, rdval);
    cpu_cycle(is_io, is_wr, m1, addr, data);
  endtask

  // ---------------- bus monitor ----------------
  bit   mon_en = 1'b0;
  bit   m_in = 1'b0, m_done = 1'b0;
  int   m_waits, m_bursts;
  logic m_prev_req = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      if ((cpu_mreq | cpu_iorq) && (cpu_rd | cpu_wr)) begin
        if (!m_in) begin
          m_in = 1'b1; m_done = 1'b0; m_waits = 0; m_bursts = 0;
        end
        if (mem_req && !m_prev_req) m_bursts++;
        if (cpu_wait) m_waits++;
        else if (!m_done) begin
          exp_t e;
          m_done = 1'b1;
          if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL scoreboard_underflow: got a bus cycle, required none");
          end else begin
            e = sb.pop_front();
            check("wait_cycles", m_waits, e.waits);
            check("mem_req_bursts", m_bursts, e.bursts);
            check("layout_id", layout_id, e.layout);
            check("timeout_err", timeout_err, e.terr);
            if (e.is_rd) check("cpu_din", cpu_din, e.din);
          end
        end
      end else m_in = 1'b0;
    end
    m_prev_req = mem_req;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    reset = 1; cpu_addr = 0; cpu_dout = 0;
    cpu_rd = 0; cpu_wr = 0; cpu_mreq = 0; cpu_iorq = 0; cpu_m1 = 0;
    exp_en = 4'b0000; slot_map = '1; stray_ack = 0;
    be_after = -1; be_age = 0; be_ack = 0; be_data = 0; mem_rdata = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    check("rst_prim_reg", prim_reg, 8'h00);
    check("rst_mem_req", mem_req, 0);
    check("rst_cpu_wait", cpu_wait, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_cpu_din", cpu_din, 8'hFF);
    mon_en = 1'b1;

    // Primary register and page 1 decode.
    txn(1, 1, 0, 16'h00A8, 8'hE4, 0, 8'h00);
    txn(1, 0, 0, 16'h00A8, 8'h00, 0, 8'h00);
    txn(0, 0, 0, 16'h4000, 8'h00, 2, 8'h3C);
    // Expander in slot 3.
    exp_en = 4'b1000;
    txn(1, 1, 0, 16'h00A8, 8'hC0, 0, 8'h00);
    txn(0, 1, 0, 16'hFFFF, 8'h1B, 0, 8'h00);
    txn(0, 0, 0, 16'hFFFF, 8'h00, 0, 8'h00);
    txn(0, 0, 0, 16'hC000, 8'h00, 1, 8'h11);
    // Ack after 5 clocks, then a write, then a timeout.
    txn(0, 0, 0, 16'h8123, 8'h00, 5, 8'h5A);
    txn(0, 1, 0, 16'h2000, 8'h99, 3, 8'h00);
    txn(0, 0, 0, 16'h0100, 8'h00, -1, 8'h00);
    // Unmapped reads: plain and M1.
    slot_map = '0;
    txn(0, 0, 0, 16'h1234, 8'h00, 0, 8'h77);
    txn(0, 0, 1, 16'h5678, 8'h00, 0, 8'h77);
    slot_map = '1;
    repeat (2) @(posedge clk);

    // Reset in the middle of a WAIT.
    mon_en = 1'b0;
    be_after = -1;
    @(posedge clk); #1;
    cpu_addr = 16'h8000; cpu_mreq = 1; cpu_rd = 1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("pre_reset_mem_req", mem_req, 1);
    check("pre_reset_cpu_wait", cpu_wait, 1);
    @(posedge clk); #1;
    reset = 1; cpu_mreq = 0; cpu_rd = 0;
    @(posedge clk); #1;
    reset = 0;
    model_reset();
    @(negedge clk);
    check("mid_reset_mem_req", mem_req, 0);
    check("mid_reset_cpu_wait", cpu_wait, 0);
    check("mid_reset_timeout_err", timeout_err, 0);
    check("mid_reset_prim_reg", prim_reg, 8'h00);
    @(posedge clk); #1 stray_ack = 1;
    @(posedge clk); #1 stray_ack = 0;
    @(negedge clk);
    check("stray_ack_mem_req", mem_req, 0);
    check("stray_ack_cpu_wait", cpu_wait, 0);
    check("stray_ack_cpu_din", cpu_din, 8'hFF);
    repeat (2) @(posedge clk);
    mon_en = 1'b1;
    txn(0, 0, 0, 16'h4444, 8'h00, 0, 8'hA5);

    // Randomised traffic (no timeouts).
    for (int k = 0; k < 200; k++) begin
      int kind, aa;
      logic [15:0] ad;
      if ($urandom_range(0, 9) == 0) exp_en = 4'($urandom);
      if ($urandom_range(0, 7) == 0) slot_map = {$urandom, $urandom};
      ad = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      aa = $urandom_range(0, 6);
      kind = $urandom_range(0, 19);
      if (kind < 3)       txn(1, 1, 0, 16'h00A8, 8'($urandom), 0, 8'h00);
      else if (kind < 5)  txn(1, 0, 0, 16'h00A8, 8'h00, 0, 8'h00);
      else if (kind < 6)  txn(1, 0, 0, 16'h0098, 8'h00, 0, 8'h00);
      else if (kind < 12) txn(0, 0, 0, ad, 8'h00, aa, 8'($urandom));
      else if (kind < 17) txn(0, 1, 0, ad, 8'($urandom), aa, 8'h00);
      else                txn(0, 0, 1, ad, 8'h00, aa, 8'($urandom));
    end

    repeat (5) @(posedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
